pipe_stage_chain: RTL and testbench
===================================

# pipe_stage_chain

Parametrised chain of DEPTH pipeline registers with valid/ready back-pressure, per-stage stall with bubble insertion, and younger-stage flush. It replaces the hard-wired `enable(1'b1)` inter-stage registers of the 5-stage CPU: stage 0 is youngest (IF/ID), stage DEPTH-1 is oldest (MEM/WB). Each slot carries an opaque payload plus a destination-register tag and write flag, so hazard logic can inspect in-flight writers.

## Interface
- DEPTH, 4: number of register stages; legal range 2..8.
- DATA_W, 64: payload width in bits (data plus control bundle).
- TAG_W, 5: destination-register tag width.
- ZERO_TAG, 31: tag that never matches in forwarding compares (XZR).

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; clears all stage state.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage 0 can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- in_tag  in  TAG_W  destination register of the beat.
- in_we  in  1  beat writes its tag register.
- out_valid  out  1  stage DEPTH-1 holds a beat.
- out_ready  in  1  downstream consumes stage DEPTH-1.
- out_data  out  DATA_W  stage DEPTH-1 payload.
- out_tag  out  TAG_W  stage DEPTH-1 tag.
- out_we  out  1  stage DEPTH-1 write flag.
- stall  in  1  hold request.
- stall_stage  in  $clog2(DEPTH)  highest stage index held by stall.
- flush  in  1  squash request.
- flush_stage  in  $clog2(DEPTH)  highest stage index squashed by flush.
- stage_valid  out  DEPTH  per-stage valid bits.
- q_tag  in  TAG_W  forwarding query tag.
- fwd_hit  out  DEPTH  per-stage forwarding match.

## Operation
- Per stage i: registers v[i], d[i], t[i], w[i]. Payload registers update only on load; v updates every cycle.
- Ready chain (combinational): rdy[DEPTH] = out_ready; rdy[i] = !v[i] | rdy[i+1]; in_ready = rdy[0] & !hold[0].
- Stall: when stall=1, hold[i]=1 for every i <= stall_stage. A held stage keeps its contents and does not advance. Stage stall_stage+1 loads a bubble (v=0) if it would otherwise advance from a held stage. Stages above stall_stage behave normally (drain).
- Flush: when flush=1, v[i] clears at the next edge for every i <= flush_stage, regardless of stall or ready. The in_data beat offered that cycle is accepted (in_ready=1) and dropped.
- Priority per stage: reset > flush > stall/hold > normal advance.
- Beat at stage i moves to i+1 when v[i] & rdy[i+1] & !hold[i]; loading copies d/t/w.
- Output: out_valid=v[DEPTH-1]; beat retires on out_valid & out_ready.
- Forwarding: fwd_hit[i] = v[i] & w[i] & (t[i]==q_tag) & (q_tag!=ZERO_TAG).

## Timing
- Reset (reset=0): all v=0, d/t/w=0, out_valid=0, out_data=0, out_tag=0, out_we=0, stage_valid=0, in_ready=0 while asserted. in_ready rises combinationally after deassertion.
- Latency: accepted beat appears on out_valid exactly DEPTH cycles later with no stall or back-pressure. Throughput is 1 beat/cycle.
- Full: all v=1 and out_ready=0 gives in_ready=0. Out_ready=1 on a full chain still allows in_ready=1 (bubble-free advance).
- stall and flush apply to the edge following the cycle in which they are sampled. A single-cycle stall inserts exactly one bubble.
- Simultaneous flush and stall on overlapping stages: flushed stages clear. A held stage above flush_stage still holds.
- Reset assertion mid-operation clears all state immediately and asynchronously. There is no partial retire.
- fwd_hit and in_ready are combinational from registered state and inputs. out_* come straight from registers.

## Configuration
- PIPE_FWD_EN defined: fwd_hit logic is built as specified.
- PIPE_FWD_EN undefined: fwd_hit is tied to all zeros, q_tag is ignored, and t/w remain stored and output.

## Test plan
- Reset/latency (DEPTH=4): hold reset=0 for 3 cycles and check all outputs are 0. Release, push in_data=0xA5 with tag 3 and out_ready=1 -> out_valid=1 with out_data=0xA5 and out_tag=3 exactly 4 cycles after acceptance.
- Back-pressure: stream 6 beats 1..6 with out_ready=0 -> in_ready drops after 4 accepts. Raise out_ready -> beats emerge in order 1..6 with none lost or duplicated.
- Load-use stall: stall=1, stall_stage=1 for one cycle with stages full of 1..4 -> stages 0–1 hold and stage 2 becomes a bubble. Output sequence is 4,3,bubble,2,1 (oldest first).
- Flush: stages hold 10,11,12,13 (stage 0=13). Pulse flush=1, flush_stage=2 -> next cycle stage_valid=4'b1000. Only 10 retires, and the input beat offered that cycle is dropped.
- Flush+stall collision: flush_stage=0 and stall_stage=2 in the same cycle -> stage 0 clears and stages 1–2 hold. Async reset asserted mid-stream clears stage_valid within the same cycle.
- Forwarding (PIPE_FWD_EN): stage 2 holds tag 7 with we=1 and q_tag=7 -> fwd_hit=4'b0100. With q_tag=31 and a stage holding tag 31 -> fwd_hit=0. Without the macro, fwd_hit=0 always.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// ----------------------------------------------------------------------------
// pipe_stage_chain
//
// Chain of DEPTH pipeline registers with valid/ready back-pressure, a
// prefix stall that inserts a bubble above the held stages, and a prefix
// flush that squashes the youngest stages. Stage 0 is the youngest slot
// and stage DEPTH-1 is the oldest. Each slot carries an opaque payload and
// a destination tag with its write flag, so hazard logic can look at
// in-flight writers.
//
// Build option:
//   PIPE_FWD_EN  when defined, fwd_hit compares q_tag against every valid
//                writer in the chain. When undefined, fwd_hit is all zeros
//                and q_tag is ignored. Tags and write flags are still
//                stored and output.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset, clears every stage
//   in_valid     upstream beat present
//   in_ready     stage 0 accepts this cycle
//   in_data      upstream payload
//   in_tag       destination register of the upstream beat
//   in_we        upstream beat writes its tag register
//   out_valid    oldest stage holds a beat
//   out_ready    downstream consumes the oldest stage
//   out_data     oldest stage payload
//   out_tag      oldest stage tag
//   out_we       oldest stage write flag
//   stall        hold request
//   stall_stage  highest stage index held by stall
//   flush        squash request
//   flush_stage  highest stage index squashed by flush
//   stage_valid  per-stage valid bits
//   q_tag        forwarding query tag
//   fwd_hit      per-stage forwarding match
//
// Handshake: a beat transfers on a rising edge when valid and ready are
// both high in the cycle before it. in_ready does not depend on in_valid.
// The exception is flush: in_ready is forced high so the upstream beat
// offered that cycle is consumed and then dropped.
// ----------------------------------------------------------------------------
module pipe_stage_chain #(
    parameter int DEPTH    = 4,
    parameter int DATA_W   = 64,
    parameter int TAG_W    = 5,
    parameter int ZERO_TAG = 31
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [TAG_W-1:0]         in_tag,
    input  logic                     in_we,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_we,
    input  logic                     stall,
    input  logic [$clog2(DEPTH)-1:0] stall_stage,
    input  logic                     flush,
    input  logic [$clog2(DEPTH)-1:0] flush_stage,
    output logic [DEPTH-1:0]         stage_valid,
    input  logic [TAG_W-1:0]         q_tag,
    output logic [DEPTH-1:0]         fwd_hit
);

    // Stage state
    logic [DEPTH-1:0]  v;
    logic [DATA_W-1:0] d [DEPTH];
    logic [TAG_W-1:0]  t [DEPTH];
    logic [DEPTH-1:0]  w;

    // Per-stage control
    logic [DEPTH:0]    rdy;      // rdy[i]: stage i can take a beat this edge
    logic [DEPTH-1:0]  hold;     // stage is frozen by stall
    logic [DEPTH-1:0]  flsh;     // stage is squashed by flush
    logic [DEPTH-1:0]  mv;       // beat leaves stage i (advances or retires)
    logic [DEPTH-1:0]  src_mv;   // a beat arrives into stage i
    logic [DATA_W-1:0] src_d [DEPTH];
    logic [TAG_W-1:0]  src_t [DEPTH];
    logic [DEPTH-1:0]  src_w;
    logic              fire_in;

    // Stall and flush each select a prefix of stages starting at stage 0.
    // Because the prefixes always include stage 0, a stage that receives a
    // beat from below can never itself be held or squashed.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            hold[i] = stall && (i <= int'(stall_stage));
            flsh[i] = flush && (i <= int'(flush_stage));
        end
    end

    // A stage is ready when it is empty or everything above it can move;
    // equivalently, it is blocked only when it and every older stage are
    // full and downstream is not consuming.
    always_comb begin : ready_chain
        logic acc;
        acc      = out_ready;
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            acc    = acc | ~v[i];
            rdy[i] = acc;
        end
    end

    assign in_ready = reset & (flush | (rdy[0] & ~hold[0]));
    // A flushed cycle still consumes the offered beat, but it never loads.
    assign fire_in  = in_valid & in_ready & ~flush;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mv[i] = v[i] & rdy[i+1] & ~hold[i] & ~flsh[i];
        end
        src_mv[0] = fire_in;
        src_d[0]  = in_data;
        src_t[0]  = in_tag;
        src_w[0]  = in_we;
        for (int i = 1; i < DEPTH; i++) begin
            src_mv[i] = mv[i-1];
            src_d[i]  = d[i-1];
            src_t[i]  = t[i-1];
            src_w[i]  = w[i-1];
        end
    end

    // Priority per stage: flush, then hold, then load, then drain.
    // The stage just above a held stage sees no source beat, so if it
    // drains that edge it naturally becomes a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v <= '0;
            w <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d[i] <= '0;
                t[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (flsh[i]) begin
                    v[i] <= 1'b0;
                end else if (hold[i]) begin
                    v[i] <= v[i];
                end else if (src_mv[i]) begin
                    v[i] <= 1'b1;
                end else if (mv[i]) begin
                    v[i] <= 1'b0;
                end
                // Payload changes only when a beat is loaded.
                if (src_mv[i]) begin
                    d[i] <= src_d[i];
                    t[i] <= src_t[i];
                    w[i] <= src_w[i];
                end
            end
        end
    end

    assign stage_valid = v;
    assign out_valid   = v[DEPTH-1];
    assign out_data    = d[DEPTH-1];
    assign out_tag     = t[DEPTH-1];
    assign out_we      = w[DEPTH-1];

`ifdef PIPE_FWD_EN
    localparam logic [TAG_W-1:0] ZT = TAG_W'(ZERO_TAG);

    // The zero register never forwards, whatever is in flight.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            fwd_hit[i] = v[i] & w[i] & (t[i] == q_tag) & (q_tag != ZT);
        end
    end
`else
    logic unused_q_tag;
    assign unused_q_tag = ^q_tag;
    assign fwd_hit      = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// ----------------------------------------------------------------------------
// tb_pipe_stage_chain
//
// Directed bench for pipe_stage_chain (DEPTH=4). A slot-level model tracks
// which beat sits in which stage and is compared with the DUT on every
// falling edge. Hand-computed literal checks pin the model at key points.
// A scoreboard queue checks ordering across the back-pressure test.
// ----------------------------------------------------------------------------
module tb_pipe_stage_chain;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 64;
    localparam int TAG_W  = 5;
    localparam logic [TAG_W-1:0] ZTAG = 5'd31;

    // ------------------------------------------------------------------
    // Clock / reset and DUT
    // ------------------------------------------------------------------
    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid, in_ready, in_we;
    logic [DATA_W-1:0] in_data;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid, out_ready, out_we;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              stall, flush;
    logic [1:0]        stall_stage, flush_stage;
    logic [DEPTH-1:0]  stage_valid, fwd_hit;
    logic [TAG_W-1:0]  q_tag;

    always #5 clk = ~clk;

    pipe_stage_chain #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .ZERO_TAG(31)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_tag(in_tag), .in_we(in_we),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_we(out_we),
        .stall(stall), .stall_stage(stall_stage),
        .flush(flush), .flush_stage(flush_stage),
        .stage_valid(stage_valid), .q_tag(q_tag), .fwd_hit(fwd_hit)
    );

    // ------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Slot model: each stage is either empty or holds one beat.
    // ------------------------------------------------------------------
    typedef struct {
        bit                v;
        logic [DATA_W-1:0] d;
        logic [TAG_W-1:0]  t;
        bit                w;
    } slot_t;

    slot_t            m    [DEPTH];
    slot_t            m_nx [DEPTH];
    bit               m_full, m_rdy, m_blocked;
    logic [DEPTH-1:0] m_sv, m_fwd;

    // The chain refuses input only when every slot is occupied and the
    // exit is closed, or while stalled (unless flushing) or in reset.
    always_comb begin
        m_full = !out_ready;
        for (int i = 0; i < DEPTH; i++) m_full = m_full && m[i].v;
        if (!reset)      m_rdy = 1'b0;
        else if (flush)  m_rdy = 1'b1;
        else if (stall)  m_rdy = 1'b0;
        else             m_rdy = !m_full;
    end

    // Next occupancy: walk from the oldest slot down. A beat leaves its
    // slot when it is not stalled, not squashed and the slots above it
    // are not a solid full block against a closed exit.
    always_comb begin
        m_blocked = !out_ready;
        for (int i = 0; i < DEPTH; i++) m_nx[i] = m[i];
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (m[i].v && !(stall && i <= int'(stall_stage)) &&
                !(flush && i <= int'(flush_stage)) && !m_blocked) begin
                m_nx[i].v = 1'b0;
                if (i < DEPTH - 1) m_nx[i+1] = m[i];
            end
            m_blocked = m_blocked && m[i].v;
        end
        if (in_valid && m_rdy && !flush)
            m_nx[0] = '{v: 1'b1, d: in_data, t: in_tag, w: in_we};
        if (flush)
            for (int i = 0; i <= int'(flush_stage); i++) m_nx[i].v = 1'b0;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            m_sv[i] = m[i].v;
`ifdef PIPE_FWD_EN
            m_fwd[i] = m[i].v && m[i].w && (m[i].t == q_tag) && (q_tag != ZTAG);
`else
            m_fwd[i] = 1'b0;
`endif
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) m[i] = '{v: 1'b0, d: '0, t: '0, w: 1'b0};
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                for (int i = 0; i < DEPTH; i++) m[i] = '{v: 1'b0, d: '0, t: '0, w: 1'b0};
            end else begin
                for (int i = 0; i < DEPTH; i++) m[i] = m_nx[i];
            end
        end
    end

    // Compare process: every falling edge
    initial forever begin
        @(negedge clk);
        check("stage_valid", stage_valid, m_sv);
        check("in_ready", in_ready, m_rdy);
        check("out_valid", out_valid, m[DEPTH-1].v);
        if (m[DEPTH-1].v) begin
            check("out_data", out_data, m[DEPTH-1].d);
            check("out_tag", out_tag, m[DEPTH-1].t);
            check("out_we", out_we, m[DEPTH-1].w);
        end
        check("fwd_hit", fwd_hit, m_fwd);
    end

    // ------------------------------------------------------------------
    // Scoreboard for ordered delivery
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] exp_q[$];
    bit                sb_en = 1'b0;
    int                sb_retired = 0;

    initial forever begin
        @(negedge clk);
        if (sb_en && reset) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_extra: got %0h expected no beat", out_data);
                end else begin
                    check("sb_order", out_data, exp_q.pop_front());
                    sb_retired++;
                end
            end
            if (in_valid && in_ready) exp_q.push_back(in_data);
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] val, input logic [4:0] tg, input logic we);
        in_valid = 1'b1;
        in_data  = val;
        in_tag   = tg;
        in_we    = we;
        cyc();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Expected output sequence for the load-use stall (0 = bubble)
    logic [63:0] ls_exp [5] = '{64'd4, 64'd3, 64'd0, 64'd2, 64'd1};
    bit          ls_vld [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        int  nxt, acc;
        bit  fire;
        in_valid = 0; in_data = '0; in_tag = '0; in_we = 0; out_ready = 0;
        stall = 0; stall_stage = '0; flush = 0; flush_stage = '0; q_tag = '0;

        // Reset held for three cycles: everything reads zero
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_stage_valid", stage_valid, 4'h0);
            check("rst_in_ready", in_ready, 1'b0);
            check("rst_out_valid", out_valid, 1'b0);
            check("rst_out_data", out_data, 64'h0);
            check("rst_out_tag", out_tag, 5'd0);
            check("rst_out_we", out_we, 1'b0);
        end
        cyc();
        reset = 1'b1;
        #1;
        check("in_ready_after_reset", in_ready, 1'b1);

        // Latency: one beat, visible DEPTH cycles after it is offered
        in_valid = 1; in_data = 64'hA5; in_tag = 5'd3; in_we = 1; out_ready = 1;
        cyc();
        in_valid = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("lat_out_valid", out_valid, (k == 4));
            if (k == 4) begin
                check("lat_out_data", out_data, 64'hA5);
                check("lat_out_tag", out_tag, 5'd3);
            end
        end
        cyc();

        // Back-pressure: six beats against a closed exit
        out_ready = 0; sb_en = 1; nxt = 1; acc = 0;
        in_valid = 1; in_data = 64'(nxt); in_tag = 5'(nxt); in_we = 1;
        for (int k = 0; k < 12 && acc < 4; k++) begin
            @(negedge clk);
            fire = in_ready;
            cyc();
            if (fire) begin
                acc++; nxt++; in_data = 64'(nxt); in_tag = 5'(nxt);
            end
        end
        check("bp_accepts", acc, 4);
        @(negedge clk);
        check("bp_in_ready_full", in_ready, 1'b0);
        check("bp_stage_full", stage_valid, 4'hF);
        cyc();
        out_ready = 1;
        for (int k = 0; k < 20 && acc < 6; k++) begin
            @(negedge clk);
            fire = in_ready;
            cyc();
            if (fire) begin
                acc++; nxt++; in_data = 64'(nxt); in_tag = 5'(nxt);
            end
        end
        in_valid = 0;
        repeat (8) cyc();
        check("bp_retired", sb_retired, 6);
        check("bp_queue_empty", exp_q.size(), 0);
        sb_en = 0;

        // Load-use stall: one-cycle stall of stages 0..1 on a full chain
        out_ready = 0;
        push(64'd4, 5'd4, 1'b1);
        push(64'd3, 5'd3, 1'b1);
        push(64'd2, 5'd2, 1'b1);
        push(64'd1, 5'd1, 1'b1);
        out_ready = 1; stall = 1; stall_stage = 2'd1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) check("ls_in_ready_stalled", in_ready, 1'b0);
            check("ls_out_valid", out_valid, ls_vld[k]);
            if (ls_vld[k]) check("ls_out_data", out_data, ls_exp[k]);
            cyc();
            stall = 0;
        end

        // Flush of stages 0..2 while the exit is closed
        out_ready = 0;
        push(64'd10, 5'd10, 1'b1);
        push(64'd11, 5'd11, 1'b1);
        push(64'd12, 5'd12, 1'b1);
        push(64'd13, 5'd13, 1'b1);
        flush = 1; flush_stage = 2'd2; in_valid = 1; in_data = 64'd99; in_tag = 5'd9;
        @(negedge clk);
        check("fl_in_ready", in_ready, 1'b1);
        cyc();
        flush = 0; in_valid = 0;
        @(negedge clk);
        check("fl_stage_valid", stage_valid, 4'b1000);
        check("fl_out_data", out_data, 64'd10);
        cyc();
        out_ready = 1;
        @(negedge clk);
        check("fl_retire_valid", out_valid, 1'b1);
        check("fl_retire_data", out_data, 64'd10);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("fl_no_more", out_valid, 1'b0);
        end
        cyc();

        // Flush stage 0 while stalling stages 0..2, exit open
        out_ready = 0;
        push(64'd20, 5'd20, 1'b1);
        push(64'd21, 5'd21, 1'b1);
        push(64'd22, 5'd22, 1'b1);
        push(64'd23, 5'd23, 1'b1);
        out_ready = 1; flush = 1; flush_stage = 2'd0; stall = 1; stall_stage = 2'd2;
        cyc();
        flush = 0; stall = 0; out_ready = 0;
        @(negedge clk);
        check("fs_stage_valid", stage_valid, 4'b0110);
        check("fs_out_valid", out_valid, 1'b0);
        cyc();

        // Asynchronous reset in the middle of traffic
        out_ready = 1; in_valid = 1; in_data = 64'd30; in_tag = 5'd30;
        cyc();
        cyc();
        reset = 1'b0;
        in_valid = 0;
        #1;
        check("ar_stage_valid", stage_valid, 4'h0);
        check("ar_out_valid", out_valid, 1'b0);
        check("ar_in_ready", in_ready, 1'b0);
        check("ar_out_data", out_data, 64'h0);
        check("ar_out_tag", out_tag, 5'd0);
        cyc();
        reset = 1'b1;
        cyc();

        // Forwarding: stage3 tag5/we, stage2 tag7/we, stage1 tag31/we,
        // stage0 tag7 without write
        out_ready = 0;
        push(64'h100, 5'd5, 1'b1);
        push(64'h101, 5'd7, 1'b1);
        push(64'h102, 5'd31, 1'b1);
        push(64'h103, 5'd7, 1'b0);
        q_tag = 5'd7;
        @(negedge clk);
`ifdef PIPE_FWD_EN
        check("fwd_tag7", fwd_hit, 4'b0100);
`else
        check("fwd_tag7", fwd_hit, 4'b0000);
`endif
        cyc();
        q_tag = 5'd31;
        @(negedge clk);
        check("fwd_zero_tag", fwd_hit, 4'b0000);
        cyc();
        q_tag = 5'd5;
        @(negedge clk);
`ifdef PIPE_FWD_EN
        check("fwd_tag5", fwd_hit, 4'b1000);
`else
        check("fwd_tag5", fwd_hit, 4'b0000);
`endif
        cyc();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
